led_btn_ctrl: RTL and testbench

// - Sequencing controller for the Nexys4 switch/button/LED path: 4 switches drive 4 LEDs, the button blanks them.
// - Adds input synchronisation, button debounce and a press-type FSM:
//   - short press toggles LIVE <-> FROZEN (LEDs hold a captured switch value);
//   - any press blanks the LEDs while the button is held.
// - Sits between board pins and LEDs; all outputs are registered.

---
 rtl/led_btn_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_led_btn_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_btn_ctrl.sv
// led_btn_ctrl
//
// Purpose:
//   Sequencing controller for the Nexys4 switch/button/LED path. Four switches
//   drive four LEDs. A debounced push button blanks the LEDs while it is held.
//   A short press toggles between LIVE (LEDs follow the switches) and FROZEN
//   (LEDs hold a switch value captured on release). A long press blanks the
//   LEDs and then returns to the mode it started from, with no other change.
//
// Ports:
//   clk        in   1  system clock, single clock domain
//   rst_n      in   1  asynchronous active-low reset
//   swt        in   4  raw switches, asynchronous to clk
//   btn        in   1  raw push button, asynchronous, bouncy, active-high
//   led        out  4  LED drive, registered
//   frozen_o   out  1  FROZEN mode, including a press that started in FROZEN
//   pressed_o  out  1  FSM is in PRESSED (debounced button held)
//
// Reset:
//   rst_n asserts asynchronously. It must be released synchronously to clk by
//   the board-level reset block. Release latencies are counted from that edge.

module led_btn_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] swt,
    input  logic       btn,
    output logic [3:0] led,
    output logic       frozen_o,
    output logic       pressed_o
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_LIVE    = 2'd0,
        ST_FROZEN  = 2'd1,
        ST_PRESSED = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][3:0] swt_sync_q, swt_sync_d;
    logic [SYNC_STAGES-1:0]      btn_sync_q, btn_sync_d;
    logic [3:0]                  swt_s;
    logic                        btn_s;

    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              btn_db_q, btn_db_d;

    state_t            state_q, state_d;
    state_t            origin_q, origin_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        frozen_val_q, frozen_val_d;

    logic [3:0]        led_q, led_d;
    logic              frozen_q, frozen_d;
    logic              pressed_q, pressed_d;

    // Synchroniser shift chains. Index 0 takes the raw pin and the oldest
    // stage feeds the rest of the design.
    always_comb begin
        swt_sync_d = {swt_sync_q[SYNC_STAGES-2:0], swt};
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn};
    end

    assign swt_s = swt_sync_q[SYNC_STAGES-1];
    assign btn_s = btn_sync_q[SYNC_STAGES-1];

    // Debounce. The counter runs only while the synchronised button differs
    // from the accepted level, so any agreeing sample restarts it. The change
    // is accepted on the cycle the run reaches DEBOUNCE_CYCLES, which is why
    // the count is compared against DEBOUNCE_CYCLES-1.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // Press-type FSM. LIVE and FROZEN are only ever entered with the debounced
    // button low, so seeing it high in those states is the rising edge. The
    // hold counter saturates at LONG_CYCLES, so a long press never wraps back
    // into looking short.
    always_comb begin
        state_d      = state_q;
        origin_d     = origin_q;
        hold_d       = hold_q;
        frozen_val_d = frozen_val_q;
        case (state_q)
            ST_LIVE: begin
                if (btn_db_q) begin
                    state_d  = ST_PRESSED;
                    origin_d = ST_LIVE;
                    hold_d   = '0;
                end
            end
            ST_FROZEN: begin
                if (btn_db_q) begin
                    state_d  = ST_PRESSED;
                    origin_d = ST_FROZEN;
                    hold_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (!btn_db_q) begin
                    if (hold_q < HOLD_W'(LONG_CYCLES)) begin
                        if (origin_q == ST_LIVE) begin
                            state_d      = ST_FROZEN;
                            frozen_val_d = swt_s;
                        end else begin
                            state_d = ST_LIVE;
                        end
                    end else begin
                        state_d = origin_q;
                    end
                end else if (hold_q != HOLD_W'(LONG_CYCLES)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_LIVE;
            end
        endcase
    end

    // Outputs are decoded from the next state. This makes the LEDs change in
    // the same cycle the FSM changes mode, rather than one cycle later.
    always_comb begin
        case (state_d)
            ST_PRESSED: led_d = 4'h0;
            ST_FROZEN:  led_d = frozen_val_d;
            default:    led_d = swt_s;
        endcase
        frozen_d  = (state_d == ST_FROZEN) ||
                    ((state_d == ST_PRESSED) && (origin_d == ST_FROZEN));
        pressed_d = (state_d == ST_PRESSED);
    end

    // All state lives here. Every flop clears on reset, so a button that is
    // still held after reset is debounced again from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swt_sync_q   <= '0;
            btn_sync_q   <= '0;
            db_cnt_q     <= '0;
            btn_db_q     <= 1'b0;
            state_q      <= ST_LIVE;
            origin_q     <= ST_LIVE;
            hold_q       <= '0;
            frozen_val_q <= 4'h0;
            led_q        <= 4'h0;
            frozen_q     <= 1'b0;
            pressed_q    <= 1'b0;
        end else begin
            swt_sync_q   <= swt_sync_d;
            btn_sync_q   <= btn_sync_d;
            db_cnt_q     <= db_cnt_d;
            btn_db_q     <= btn_db_d;
            state_q      <= state_d;
            origin_q     <= origin_d;
            hold_q       <= hold_d;
            frozen_val_q <= frozen_val_d;
            led_q        <= led_d;
            frozen_q     <= frozen_d;
            pressed_q    <= pressed_d;
        end
    end

    assign led       = led_q;
    assign frozen_o  = frozen_q;
    assign pressed_o = pressed_q;

endmodule

// File: tb/tb_led_btn_ctrl.sv
// tb_led_btn_ctrl
//
// Purpose:
//   Testbench for led_btn_ctrl. The DUT runs with SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4 and LONG_CYCLES=20. A reference model pushes one
//   expected output word per clock edge into a queue. An independent monitor
//   pops that word and compares it with the DUT outputs. Directed sequences
//   also check fixed values at the latencies of interest.

module tb_led_btn_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int HIST = SYNC + DEB + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] swt   = 4'h0;
    logic       btn   = 1'b0;
    logic [3:0] led;
    logic       frozen_o;
    logic       pressed_o;

    int total   = 0;
    int bad     = 0;
    bit running = 1'b1;

    typedef struct packed {
        logic [3:0] led;
        logic       frz;
        logic       prs;
    } exp_t;

    exp_t exp_q[$];

    led_btn_ctrl #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .swt      (swt),
        .btn      (btn),
        .led      (led),
        .frozen_o (frozen_o),
        .pressed_o(pressed_o)
    );

    // 100 MHz-style clock with a 10-unit period.
    always #5 clk = ~clk;

    // Reference model state. It keeps the raw pin history, the accepted
    // button level, the current mode, and when the current press began.
    logic [3:0] m_swt_h[$];
    logic       m_btn_h[$];
    logic       m_db       = 1'b0;
    logic       m_mode_frz = 1'b0;
    logic       m_pressed  = 1'b0;
    logic [3:0] m_fval     = 4'h0;
    int         m_cyc      = 0;
    int         m_start    = 0;

    function automatic logic [3:0] swtAt(input int i);
        if (i < m_swt_h.size()) return m_swt_h[i];
        return 4'h0;
    endfunction

    function automatic logic btnAt(input int i);
        if (i < m_btn_h.size()) return m_btn_h[i];
        return 1'b0;
    endfunction

    // Model step, one per clock edge. A pin value seen SYNC edges ago is what
    // the logic sees now. A button change counts once DEB consecutive
    // synchronised samples disagree with the accepted level. The FSM reacts
    // to the accepted level one edge after it changes. A press is short when
    // fewer than LONG edges passed strictly between entering PRESSED and
    // seeing the release.
    always @(posedge clk) begin : model
        exp_t       e;
        logic [3:0] s_now;
        logic       all_diff;
        int         len;
        if (!rst_n) begin
            m_swt_h.delete();
            m_btn_h.delete();
            m_db       = 1'b0;
            m_mode_frz = 1'b0;
            m_pressed  = 1'b0;
            m_fval     = 4'h0;
            m_cyc      = 0;
            m_start    = 0;
            e          = '0;
        end else begin
            m_cyc++;
            m_swt_h.push_front(swt);
            m_btn_h.push_front(btn);
            if (m_swt_h.size() > HIST) void'(m_swt_h.pop_back());
            if (m_btn_h.size() > HIST) void'(m_btn_h.pop_back());
            s_now = swtAt(SYNC);
            if (!m_pressed && m_db) begin
                m_pressed = 1'b1;
                m_start   = m_cyc;
            end else if (m_pressed && !m_db) begin
                len       = m_cyc - m_start - 1;
                m_pressed = 1'b0;
                if (len < LONG) begin
                    m_mode_frz = !m_mode_frz;
                    if (m_mode_frz) m_fval = s_now;
                end
            end
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) begin
                if (btnAt(SYNC + k) == m_db) all_diff = 1'b0;
            end
            if (all_diff) m_db = !m_db;
            e.led = m_pressed ? 4'h0 : (m_mode_frz ? m_fval : s_now);
            e.frz = m_mode_frz;
            e.prs = m_pressed;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares the DUT outputs against the oldest queued
    // expectation, one step after every edge.
    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (running) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL scoreboard_empty at %0t: no expected value queued", $time);
            end else begin
                e = exp_q.pop_front();
                if ({led, frozen_o, pressed_o} !== e) begin
                    bad++;
                    $display("[TB] FAIL scoreboard at %0t: got led=%h frozen=%b pressed=%b, want led=%h frozen=%b pressed=%b",
                             $time, led, frozen_o, pressed_o, e.led, e.frz, e.prs);
                end
            end
        end
    end

    // Guard against a stalled run.
    initial begin
        #400_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] s, input logic b);
        @(negedge clk);
        swt = s;
        btn = b;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_led,
                               input logic e_frz, input logic e_prs);
        total++;
        if (led !== e_led || frozen_o !== e_frz || pressed_o !== e_prs) begin
            bad++;
            $display("[TB] FAIL %s: got led=%h frozen=%b pressed=%b, want led=%h frozen=%b pressed=%b",
                     name, led, frozen_o, pressed_o, e_led, e_frz, e_prs);
        end
    endtask

    // Hold the button for 'hold' edges (hold >= 8). Checks that PRESSED is
    // entered exactly 7 edges after the press and left exactly 7 edges after
    // the release.
    task automatic pressBtn(input int hold, input logic [3:0] pre_led, input logic origin_frz,
                            input logic [3:0] post_led, input logic post_frz);
        applyStimulus(swt, 1'b1);
        waitEdges(SYNC + DEB);
        checkOutput("press_edge6", pre_led, origin_frz, 1'b0);
        waitEdges(1);
        checkOutput("press_edge7", 4'h0, origin_frz, 1'b1);
        waitEdges(hold - (SYNC + DEB + 1));
        applyStimulus(swt, 1'b0);
        waitEdges(SYNC + DEB);
        checkOutput("release_edge6", 4'h0, origin_frz, 1'b1);
        waitEdges(1);
        checkOutput("release_edge7", post_led, post_frz, 1'b0);
    endtask

    initial begin : stimulus
        bit         flag;
        logic [3:0] cur_swt;
        logic       cur_btn;

        $display("[TB] start");
        #1 rst_n = 1'b0;

        // Reset with switches at A. The LEDs stay dark until the switch
        // value has crossed the synchroniser and been registered.
        applyStimulus(4'hA, 1'b0);
        waitEdges(3);
        checkOutput("reset_state", 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        waitEdges(2);
        checkOutput("release_edge2", 4'h0, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("release_edge3", 4'hA, 1'b0, 1'b0);

        // Single-cycle bounces must never be accepted as a press.
        applyStimulus(4'hA, 1'b1);
        waitEdges(1);
        applyStimulus(4'hA, 1'b0);
        waitEdges(1);
        applyStimulus(4'hA, 1'b1);
        waitEdges(1);
        applyStimulus(4'hA, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            waitEdges(1);
            if (pressed_o !== 1'b0 || led !== 4'hA) flag = 1'b1;
        end
        total++;
        if (flag) begin
            bad++;
            $display("[TB] FAIL bounce_ignored: got disturbance=1, want 0");
        end
        checkOutput("bounce_end", 4'hA, 1'b0, 1'b0);

        // Short press from LIVE freezes 5. Later switch changes are ignored.
        applyStimulus(4'h5, 1'b0);
        waitEdges(3);
        checkOutput("live_5", 4'h5, 1'b0, 1'b0);
        pressBtn(10, 4'h5, 1'b0, 4'h5, 1'b1);
        applyStimulus(4'hF, 1'b0);
        waitEdges(5);
        checkOutput("frozen_hold_5", 4'h5, 1'b1, 1'b0);

        // A second short press returns to LIVE showing F.
        pressBtn(10, 4'h5, 1'b1, 4'hF, 1'b0);

        // A long press in LIVE stays in LIVE, and the LEDs track again.
        pressBtn(30, 4'hF, 1'b0, 4'hF, 1'b0);
        applyStimulus(4'h9, 1'b0);
        waitEdges(3);
        checkOutput("live_after_long", 4'h9, 1'b0, 1'b0);

        // Freeze 3, then a long press in FROZEN keeps 3.
        applyStimulus(4'h3, 1'b0);
        waitEdges(3);
        checkOutput("live_3", 4'h3, 1'b0, 1'b0);
        pressBtn(10, 4'h3, 1'b0, 4'h3, 1'b1);
        applyStimulus(4'hC, 1'b0);
        waitEdges(3);
        checkOutput("frozen_3", 4'h3, 1'b1, 1'b0);
        pressBtn(30, 4'h3, 1'b1, 4'h3, 1'b1);

        // Reset in the middle of a press with the button still held.
        applyStimulus(4'hC, 1'b1);
        waitEdges(10);
        checkOutput("midpress", 4'h0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midpress_reset_now", 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitEdges(SYNC + DEB);
        checkOutput("repress_edge6", 4'hC, 1'b0, 1'b0);
        waitEdges(1);
        checkOutput("repress_edge7", 4'h0, 1'b0, 1'b1);
        applyStimulus(4'hC, 1'b0);
        waitEdges(SYNC + DEB + 1);
        checkOutput("repress_release", 4'hC, 1'b1, 1'b0);

        // Randomised phase: switch changes, short glitches and presses of
        // many lengths, including lengths around the long-press threshold.
        // Only the scoreboard checks this phase.
        $display("[TB] random phase");
        cur_swt = 4'hC;
        cur_btn = 1'b0;
        for (int it = 0; it < 150; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                cur_swt = 4'($urandom_range(0, 15));
                applyStimulus(cur_swt, cur_btn);
                waitEdges(int'($urandom_range(1, 6)));
            end else if (r <= 5) begin
                applyStimulus(cur_swt, !cur_btn);
                waitEdges(int'($urandom_range(1, 3)));
                applyStimulus(cur_swt, cur_btn);
                waitEdges(int'($urandom_range(1, 4)));
            end else begin
                cur_btn = !cur_btn;
                applyStimulus(cur_swt, cur_btn);
                waitEdges(int'($urandom_range(4, 40)));
            end
        end
        applyStimulus(cur_swt, 1'b0);
        waitEdges(50);

        @(negedge clk);
        running = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
